// File: rtl/rom_arbiter.sv
// Arbitrates a single-ported ROM between a fetch port and a burst port.
// Fetch has priority but a burst word is forced through after three consecutive fetch slots.
module rom_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [31:0] f_data,
  input  logic        b_req,
  input  logic [15:0] b_addr,
  input  logic [3:0]  b_len,
  output logic        b_gnt,
  output logic        b_valid,
  output logic [31:0] b_data,
  output logic        b_last,
  output logic        b_busy,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_data
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t      state_q, state_d;
  logic [15:0] ptr_q;
  logic [3:0]  rem_q;
  logic [1:0]  starve_q;
  logic        fetch_slot;
  logic        burst_slot;

  // b_busy is the FSM state itself: high exactly while in ST_BURST.
  assign b_busy = (state_q == ST_BURST);

  always_comb begin
    state_d    = state_q;
    fetch_slot = 1'b0;
    burst_slot = 1'b0;
    f_gnt      = 1'b0;
    b_gnt      = 1'b0;
    rom_addr   = 16'h0000;
    if (!RST) begin
      fetch_slot = f_req && ((state_q == ST_IDLE) || (starve_q != 2'd3));
      burst_slot = (state_q == ST_BURST) && !fetch_slot;
      f_gnt      = fetch_slot;
      b_gnt      = b_req && (state_q == ST_IDLE);
      if (fetch_slot) begin
        rom_addr = f_addr;
      end else if (burst_slot) begin
        rom_addr = ptr_q;
      end
      case (state_q)
        ST_IDLE:  if (b_gnt) state_d = ST_BURST;
        ST_BURST: if (burst_slot && (rem_q == 4'd0)) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 16'h0000;
      rem_q    <= 4'd0;
      starve_q <= 2'd0;
      f_valid  <= 1'b0;
      f_data   <= 32'h0;
      b_valid  <= 1'b0;
      b_data   <= 32'h0;
      b_last   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_valid <= fetch_slot;
      b_valid <= burst_slot;
      b_last  <= burst_slot && (rem_q == 4'd0);
      if (fetch_slot) f_data <= rom_data;
      if (burst_slot) b_data <= rom_data;
      // Descriptor load and word issue never coincide: b_gnt only happens in ST_IDLE.
      if (b_gnt) begin
        ptr_q <= b_addr;
        rem_q <= b_len;
      end else if (burst_slot) begin
        ptr_q <= ptr_q + 16'd1;
        rem_q <= rem_q - 4'd1;
      end
      if (state_d == ST_IDLE || burst_slot) begin
        starve_q <= 2'd0;
      end else if (fetch_slot && (state_q == ST_BURST) && (starve_q != 2'd3)) begin
        starve_q <= starve_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a transaction-level model (queue of pending burst word addresses,
// count of fetches since the last burst word) predicts every port each cycle.
module tb_rom_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt, f_valid;
  logic [31:0] f_data;
  logic        b_req;
  logic [15:0] b_addr;
  logic [3:0]  b_len;
  logic        b_gnt, b_valid, b_last, b_busy;
  logic [31:0] b_data;
  logic [15:0] rom_addr;
  logic [31:0] rom_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [15:0] burst_q[$];
  int          fetch_run;
  logic        exp_fvalid, exp_bvalid, exp_blast;
  logic [31:0] exp_fdata, exp_bdata;
  logic        last_fetch, last_bgnt;

  always #5 CLK = ~CLK;

  rom_arbiter dut (
    .CLK(CLK), .RST(RST),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data),
    .b_req(b_req), .b_addr(b_addr), .b_len(b_len), .b_gnt(b_gnt), .b_valid(b_valid),
    .b_data(b_data), .b_last(b_last), .b_busy(b_busy),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  function automatic logic [31:0] rom_fn(input logic [15:0] a);
    case (a)
      16'h0000: rom_fn = 32'h00010006;
      16'h0003: rom_fn = 32'h0000401A;
      16'h0006: rom_fn = 32'h00030050;
      default:  rom_fn = {a ^ 16'hA5C3, a + 16'h1111};
    endcase
  endfunction

  assign rom_data = rom_fn(rom_addr);

  // One clock of the scoreboard: predict and compare at negedge, advance the model at posedge.
  task automatic cycle();
    logic        busy, fetch, burst, e_fgnt, e_bgnt;
    logic [15:0] e_addr;
    @(negedge CLK);
    busy   = (burst_q.size() != 0);
    fetch  = 1'b0;
    burst  = 1'b0;
    e_bgnt = 1'b0;
    e_addr = 16'h0000;
    if (!RST) begin
      fetch  = f_req && (!busy || fetch_run < 3);
      burst  = busy && !fetch;
      e_bgnt = b_req && !busy;
      if (fetch) e_addr = f_addr;
      else if (burst) e_addr = burst_q[0];
    end
    e_fgnt = fetch;
    vectors += 9;
    if (f_gnt !== e_fgnt) begin miscompares++; $display("FAIL f_gnt got %b exp %b t=%0t", f_gnt, e_fgnt, $time); end
    if (b_gnt !== e_bgnt) begin miscompares++; $display("FAIL b_gnt got %b exp %b t=%0t", b_gnt, e_bgnt, $time); end
    if (rom_addr !== e_addr) begin miscompares++; $display("FAIL rom_addr got %h exp %h t=%0t", rom_addr, e_addr, $time); end
    if (b_busy !== busy) begin miscompares++; $display("FAIL b_busy got %b exp %b t=%0t", b_busy, busy, $time); end
    if (f_valid !== exp_fvalid) begin miscompares++; $display("FAIL f_valid got %b exp %b t=%0t", f_valid, exp_fvalid, $time); end
    if (f_data !== exp_fdata) begin miscompares++; $display("FAIL f_data got %h exp %h t=%0t", f_data, exp_fdata, $time); end
    if (b_valid !== exp_bvalid) begin miscompares++; $display("FAIL b_valid got %b exp %b t=%0t", b_valid, exp_bvalid, $time); end
    if (b_data !== exp_bdata) begin miscompares++; $display("FAIL b_data got %h exp %h t=%0t", b_data, exp_bdata, $time); end
    if (b_last !== exp_blast) begin miscompares++; $display("FAIL b_last got %b exp %b t=%0t", b_last, exp_blast, $time); end
    @(posedge CLK);
    last_fetch = fetch;
    last_bgnt  = e_bgnt;
    if (RST) begin
      burst_q.delete();
      fetch_run  = 0;
      exp_fvalid = 1'b0; exp_bvalid = 1'b0; exp_blast = 1'b0;
      exp_fdata  = 32'h0; exp_bdata = 32'h0;
    end else begin
      exp_fvalid = fetch;
      if (fetch) exp_fdata = rom_fn(f_addr);
      exp_bvalid = burst;
      exp_blast  = 1'b0;
      if (burst) begin
        exp_bdata = rom_fn(burst_q[0]);
        exp_blast = (burst_q.size() == 1);
        void'(burst_q.pop_front());
        fetch_run = 0;
      end else if (fetch && busy && fetch_run < 3) begin
        fetch_run++;
      end
      if (burst_q.size() == 0) fetch_run = 0;
      if (e_bgnt) begin
        for (int i = 0; i <= int'(b_len); i++) burst_q.push_back(b_addr + 16'(i));
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; f_req = 1'b1; f_addr = 16'h1234; b_req = 1'b1; b_addr = 16'h0040; b_len = 4'd3;
    for (int i = 0; i < 3; i++) cycle();
    RST = 1'b0;
    idle_inputs();
    cycle();
  endtask

  task automatic test_single_fetch();
    f_req = 1'b1; f_addr = 16'h0003;
    cycle();
    f_req = 1'b0;
    cycle();
    vectors++;
    if (f_data !== 32'h0000401A) begin
      miscompares++; $display("FAIL single_fetch_data got %h exp %h", f_data, 32'h0000401A);
    end
    cycle();
  endtask

  task automatic test_burst_alone();
    int pulses = 0;
    b_req = 1'b1; b_addr = 16'h0000; b_len = 4'd6;
    cycle();
    b_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (b_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 7) begin miscompares++; $display("FAIL burst_alone_pulses got %0d exp 7", pulses); end
  endtask

  task automatic test_fairness();
    int max_gap = 0, gap = 0;
    b_req = 1'b1; b_addr = 16'h0100; b_len = 4'd3;
    f_req = 1'b1; f_addr = 16'h0200;
    cycle();
    b_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      f_addr = 16'($urandom_range(0, 65535));
      cycle();
      if (last_fetch) gap = 0; else begin gap++; if (gap > max_gap) max_gap = gap; end
    end
    f_req = 1'b0;
    cycle(); cycle();
    vectors++;
    if (max_gap > 1) begin miscompares++; $display("FAIL fairness_gap got %0d exp <=1", max_gap); end
  endtask

  task automatic test_wrap();
    b_req = 1'b1; b_addr = 16'hFFFE; b_len = 4'd2;
    cycle();
    b_req = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
  endtask

  task automatic test_reset_mid_burst();
    int words = 0;
    b_req = 1'b1; b_addr = 16'h0010; b_len = 4'd5;
    cycle();
    b_req = 1'b0;
    for (int i = 0; i < 10 && words < 2; i++) begin
      cycle();
      if (b_valid === 1'b1) words++;
    end
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (b_valid !== 1'b0) begin miscompares++; $display("FAIL reset_abort_bvalid got %b exp 0", b_valid); end
    end
    test_single_fetch();
  endtask

  task automatic test_busy_reject();
    int accepts = 0;
    b_req = 1'b1; b_addr = 16'h0300; b_len = 4'd4;
    cycle();
    b_addr = 16'h0400; b_len = 4'd1;
    for (int i = 0; i < 12 && accepts == 0; i++) begin
      cycle();
      if (last_bgnt) accepts++;
    end
    b_req = 1'b0;
    vectors++;
    if (accepts != 1) begin miscompares++; $display("FAIL busy_reject_accepts got %0d exp 1", accepts); end
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      if (!f_req || last_fetch) begin
        f_req  = ($urandom_range(0, 2) != 0);
        f_addr = 16'($urandom_range(0, 65535));
      end
      if (!b_req || last_bgnt) begin
        b_req  = ($urandom_range(0, 5) == 0);
        b_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                             : 16'($urandom_range(0, 65535));
        b_len  = 4'($urandom_range(0, 15));
      end
      RST = ($urandom_range(0, 60) == 0);
      cycle();
    end
    RST = 1'b0;
    idle_inputs();
    for (int i = 0; i < 40; i++) cycle();
  endtask

  initial begin
    fetch_run = 0;
    exp_fvalid = 1'b0; exp_bvalid = 1'b0; exp_blast = 1'b0;
    exp_fdata = 32'h0; exp_bdata = 32'h0;
    last_fetch = 1'b0; last_bgnt = 1'b0;
    f_addr = 16'h0; b_addr = 16'h0; b_len = 4'd0;
    #1;
    test_reset();
    test_single_fetch();
    test_burst_alone();
    test_fairness();
    test_wrap();
    test_reset_mid_burst();
    test_busy_reject();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameters: none; address width fixed at 16, data width fixed at 32.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 f_req  input  1  fetch port request; held with f_addr stable until f_gnt.
REQ-005 f_addr  input  16  fetch word address.
REQ-006 f_gnt  output  1  combinational; fetch access issued this cycle.
REQ-007 f_valid  output  1  registered; f_data valid, one-cycle pulse.
REQ-008 f_data  output  32  registered fetch read data.
REQ-009 b_req  input  1  burst port request; held with b_addr/b_len stable until b_gnt.
REQ-010 b_addr  input  16  burst base word address.
REQ-011 b_len  input  4  burst length minus one (1..16 words).
REQ-012 b_gnt  output  1  combinational; burst descriptor accepted this cycle.
REQ-013 b_valid  output  1  registered; b_data valid, one-cycle pulse per word.
REQ-014 b_data  output  32  registered burst read data.
REQ-015 b_last  output  1  registered; qualifies final b_valid of a burst.
REQ-016 b_busy  output  1  registered; burst accepted and not yet fully issued.
REQ-017 rom_addr  output  16  combinational address to the ROM.
REQ-018 rom_data  input  32  combinational ROM read data for rom_addr.

Function
REQ-019 At most one ROM access ("slot") per cycle; each slot is FETCH, BURST or IDLE.
REQ-020 States: IDLE (b_busy=0) and BURST (b_busy=1); IDLE->BURST on b_gnt; BURST->IDLE on the slot issuing the final word.
REQ-021 b_gnt = b_req & ~b_busy; on b_gnt latch base address into word pointer and b_len into remaining count.
REQ-022 No burst word is issued in the b_gnt cycle; the first burst word is eligible in the following cycle.
REQ-023 Slot choice: fetch if f_req and (not BURST or starve count < 3); else burst word if BURST; else IDLE.
REQ-024 Starve count (2-bit): increments on each FETCH slot while BURST; clears on each BURST slot and on entry to IDLE; saturates at 3.
REQ-025 When starve count = 3 in BURST, the slot goes to burst even if f_req; f_gnt=0 that cycle.
REQ-026 rom_addr = f_addr in FETCH slot, word pointer in BURST slot, 16'h0000 in IDLE slot.
REQ-027 Read latency 1: data from rom_data is registered at the slot's clock edge; f_valid/b_valid high the next cycle.
REQ-028 Each BURST slot: pointer increments by 1 modulo 2^16 (16'hFFFF wraps to 16'h0000), remaining count decrements.
REQ-029 b_last=1 with b_valid for the word issued when remaining count was 0; b_busy falls the cycle after that slot.
REQ-030 f_data/b_data hold last value when respective valid is low.
REQ-031 Back-to-back fetches: f_req held high yields f_gnt every eligible cycle, one f_valid per f_gnt.
REQ-032 New b_req while b_busy is ignored (b_gnt=0) until return to IDLE; next burst accept possible the cycle b_busy reads 0.

Reset
REQ-033 RST=1 at a clock edge: f_valid, b_valid, b_last, b_busy, f_data, b_data, word pointer, remaining count, starve count all to 0; state IDLE.
REQ-034 Reset mid-burst aborts the burst: no b_valid in the cycle after reset and none afterwards for that burst.
REQ-035 While RST=1, f_gnt and b_gnt SHALL be 0 and rom_addr 16'h0000.

Verification
REQ-036 Single fetch: f_req=1, f_addr=16'h0003, ROM returns 32'h0000401A -> f_gnt same cycle, next cycle f_valid=1, f_data=32'h0000401A.
REQ-037 Burst alone: b_addr=16'h0000, b_len=6 -> b_gnt one cycle, then 7 b_valid pulses on consecutive cycles, data 32'h00010006..32'h00030050, b_last on 7th, b_busy low next cycle.
REQ-038 Fairness: f_req continuously high during burst b_len=3 -> repeating pattern 3 fetch slots then 1 burst slot; all 4 burst words delivered, fetch never starved more than 1 cycle.
REQ-039 Wrap: b_addr=16'hFFFE, b_len=2 -> rom_addr sequence 16'hFFFE, 16'hFFFF, 16'h0000.
REQ-040 Reset mid-burst: RST pulse after 2nd burst word of b_len=5 -> b_busy=0, no further b_valid, subsequent single fetch behaves as REQ-036.
REQ-041 Busy rejection: second b_req during active burst -> b_gnt=0 until b_busy=0, then accepted in that cycle.
